// File: rtl/aes_128_key_expand.sv
// AES-128 key schedule: expands key_in into 11 round keys and streams them as 22
// 64-bit halves into the round-key RAM, using an external 1-cycle registered S-box.
module aes_128_key_expand #(
    parameter int ADDR_BASE = 0,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              kill,
    input  logic              key_start,
    input  logic [127:0]      key_in,
    output logic              busy,
    output logic              done,
    output logic              en_wr,
    output logic [ADDR_W-1:0] addr,
    output logic [63:0]       key_round_wr,
    output logic [31:0]       sbox_addr,
    input  logic [31:0]       sbox_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        SB_REQ,
        SB_WAIT,
        DONE
    } state_t;

    state_t       state, state_nxt;
    logic [127:0] k_reg;
    logic [3:0]   r_reg;
    logic [7:0]   rcon;

    logic [31:0] t_word, w0_n, w1_n, w2_n, w3_n;
    logic [7:0]  rcon_n;
    logic [ADDR_W-1:0] addr_lo;

    // RotWord(w3), presented continuously so the BRAM sees it in SB_REQ.
    assign sbox_addr = {k_reg[103:96], k_reg[127:104]};

    always_comb begin
        t_word = sbox_data ^ {24'h0, rcon};
        w0_n   = k_reg[31:0]   ^ t_word;
        w1_n   = k_reg[63:32]  ^ w0_n;
        w2_n   = k_reg[95:64]  ^ w1_n;
        w3_n   = k_reg[127:96] ^ w2_n;
        rcon_n = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; kill clears everything asynchronously.
    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            k_reg <= '0;
            r_reg <= '0;
            rcon  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_start) begin
                        k_reg <= key_in;
                        r_reg <= '0;
                        rcon  <= 8'h01;
                    end
                end
                SB_WAIT: begin
                    k_reg <= {w3_n, w2_n, w1_n, w0_n};
                    r_reg <= r_reg + 4'd1;
                    rcon  <= rcon_n;
                end
                default: ;
            endcase
        end
    end

    assign addr_lo = ADDR_W'(ADDR_BASE) + ADDR_W'({r_reg, 1'b0});

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        en_wr        = 1'b0;
        addr         = '0;
        key_round_wr = '0;
        done         = 1'b0;
        case (state)
            IDLE:    if (key_start) state_nxt = WR_LO;
            WR_LO: begin
                en_wr        = 1'b1;
                addr         = addr_lo;
                key_round_wr = k_reg[63:0];
                state_nxt    = WR_HI;
            end
            WR_HI: begin
                en_wr        = 1'b1;
                addr         = addr_lo + ADDR_W'(1);
                key_round_wr = k_reg[127:64];
                state_nxt    = (r_reg == 4'd10) ? DONE : SB_REQ;
            end
            SB_REQ:  state_nxt = SB_WAIT;
            SB_WAIT: state_nxt = WR_LO;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/aes_128_key_expand.md
Name: aes_128_key_expand

Overview:
- Upstream producer for the round-key RAM (aes_128_keyram_mem).
- On a start pulse, expands a 128-bit AES-128 cipher key into 11 round keys.
- Writes them as 22 sequential 64-bit halves through the RAM's en_wr/addr/key_round_wr write port.
- SubWord uses an external registered S-box BRAM port with 4 byte lanes and 1-cycle read latency.

Parameters:
- ADDR_BASE, 0, RAM address of round 0 low half; round r low half goes to ADDR_BASE+2r, high half to ADDR_BASE+2r+1.
- ADDR_W, 5, width of addr; must cover ADDR_BASE+21.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- kill  in  1  reset; asynchronous, active-high.
- key_start  in  1  one-cycle start request; sampled only in IDLE.
- key_in  in  128  cipher key; byte i sits at [8i+7:8i] (key 00 01 .. 0f is 128'h0f0e..0100).
- busy  out  1  high from the cycle after key_start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse after the last RAM write.
- en_wr  out  1  RAM write enable.
- addr  out  ADDR_W  RAM write address.
- key_round_wr  out  64  RAM write data.
- sbox_addr  out  32  four S-box lookup addresses, one per byte lane.
- sbox_data  in  32  S-box results; lane j valid one cycle after sbox_addr lane j is presented.

Behaviour:
- State: K[127:0] holds the current round key (words w0..w3 = K[31:0]..K[127:96]); r[3:0] is the round counter; rcon[7:0] is the round constant.
- FSM states: IDLE, WR_LO, WR_HI, SB_REQ, SB_WAIT, DONE.
- IDLE: when key_start=1, load K<=key_in, r<=0, rcon<=8'h01, go to WR_LO. Otherwise stay.
- WR_LO: en_wr=1, addr=ADDR_BASE+2r, key_round_wr=K[63:0]; go to WR_HI.
- WR_HI: en_wr=1, addr=ADDR_BASE+2r+1, key_round_wr=K[127:64]. If r==10 go to DONE, else go to SB_REQ.
- SB_REQ: no write; go to SB_WAIT. The BRAM samples sbox_addr at the end of this cycle.
- sbox_addr = RotWord(w3) = {K[103:96], K[127:104]} at all times (pure function of K).
- SB_WAIT: sample sbox_data and update the key:
  - t = sbox_data ^ {24'h0, rcon}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - K <= {w3', w2', w1', w0'}, r <= r+1
  - rcon <= xtime(rcon): {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00)
  - go to WR_LO.
- DONE: done=1 for exactly one cycle; go to IDLE.
- en_wr, addr, key_round_wr and done are Moore outputs decoded from the state/K/r registers only.
- In states with en_wr=0: addr=0 and key_round_wr=0.
- busy = (state != IDLE).
- Timing (key_start sampled at edge 0): round 0 writes in cycles 1-2; round r (1..10) writes in cycles 4r+1 and 4r+2; last write in cycle 42; done in cycle 43; IDLE again at cycle 44. A new key_start is accepted in cycle 44.
- key_start while busy is ignored and not queued. key_in is sampled only on acceptance; later changes have no effect.
- sbox_data is sampled only in SB_WAIT; its value in other cycles is don't-care.
- kill asserted at any time, including mid-expansion: immediately clears state to IDLE and clears K, r, rcon and all outputs to 0 (busy=0, done=0, en_wr=0, addr=0, key_round_wr=0). RAM entries already written stay as written; there is no rollback. After kill is released, only a fresh key_start restarts.
- Reset values: every output is 0. sbox_addr = 0 because K = 0.

Test Plan:
1. FIPS-197 key 000102..0f (key_in=128'h0f0e0d0c0b0a09080706050403020100), behavioral 1-cycle registered S-box -> 22 writes:
   - addr0=64'h0706050403020100, addr1=64'h0f0e0d0c0b0a0908
   - addr2=64'hfa72afd2fd74aad6, addr3=64'hfe76abd6f178a6da
   - addr20=64'h174a94e37f1d1113, addr21=64'hc5302b4d8ba707f3
   - loaded into aes_128_keyram_mem, contents equal this table.
2. FIPS-197 key 2b7e1516..4f3c (key_in=128'h3c4fcf098815f7aba6d2ae2816157e2b) -> addr20=64'h8925eec9a8f914d0, addr21=64'ha60c63b6c80c3fe1.
3. Timing: key_start at edge 0 ->
   - en_wr high in exactly 22 cycles (1,2,5,6,...,41,42)
   - done high only in cycle 43
   - busy high in cycles 1-43.
4. key_start re-pulsed in cycle 10 with a different key_in -> ignored; write stream identical to scenario 1.
5. kill asserted in cycle 20 -> same cycle: busy=0, en_wr=0, addr=0. Release, then key_start -> full correct 22-write sequence from addr 0.
6. Back-to-back: key_start in cycle 44 (first IDLE cycle after done) -> accepted; second expansion completes with done in cycle 87.
